// File: rtl/uc_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier control unit.
package uc_mult_pkg;

  localparam int NREQ = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    ADD   = 3'b010,
    SHIFT = 3'b011,
    DONE  = 3'b100
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the requester that did not own the datapath last wins a tie.
module rr_arb2
  import uc_mult_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/uc_mult_arb.sv
// Control unit for the shared shift-and-add multiplier: arbitrates two requesters
// round-robin and sequences one WIDTH-bit multiplication for the owner.
//
//   state | meaning
//   IDLE  | datapath free, arbitrate on req
//   LOAD  | load Q with multiplier, clear A, clear iteration counter
//   ADD   | A <= A + multiplicand when q0 is set
//   SHIFT | shift {A,Q} right, advance or finish iteration
//   DONE  | Fin pulse, remember owner for round-robin
module uc_mult_arb
  import uc_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            q0,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            CargaQ,
  output logic            ResetA,
  output logic            CargaA,
  output logic            DesplazaQ,
  output logic            Fin
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic [NREQ-1:0] grant_q;
  logic            last_q;
  logic [NREQ-1:0] gnt_cand;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .gnt  (gnt_cand)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= LOAD;
            grant_q <= gnt_cand;
          end else begin
            grant_q <= '0;
          end
        end
        LOAD: begin
          count_q <= '0;
          state_q <= ADD;
        end
        ADD: state_q <= SHIFT;
        SHIFT: begin
          if (count_q == CNT_LAST) begin
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
            state_q <= ADD;
          end
        end
        DONE: begin
          last_q  <= grant_q[1];
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  // CargaA is the only output that looks at a live input (q0).
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign CargaQ    = (state_q == LOAD);
  assign ResetA    = (state_q == LOAD);
  assign CargaA    = (state_q == ADD) & q0;
  assign DesplazaQ = (state_q == SHIFT);
  assign Fin       = (state_q == DONE);

endmodule
